snake_body_sequencer: RTL and testbench

- Owns the snake position state: the head coordinate plus the ordered body/tail list.
- Advances the snake one grid block per game step, grows it when fruit is eaten, and detects wall and self collisions.
- Once per frame, during vsync, serially streams the body list to the graphics renderer over snake_body_x/y with en_snake_body.
- Sits between the game-logic tick/direction source and graphic_game.

---
 rtl/snake_body_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_snake_body_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_sequencer.sv
// Snake position state: advances/grows the head-plus-body list per game step, flags wall and self hits,
// and streams the 15-entry body list once per vsync (move result in 2 cycles; stream stalls while frame_tik is low).
module snake_body_sequencer #(
   parameter int SNAKE_LENGTH_BIT = 4,
   parameter int SNAKE_LENGTH_MAX = 16,
   parameter int GRID_X_MAX       = 123,
   parameter int GRID_Y_MAX       = 80,
   parameter int START_X          = 60,
   parameter int START_Y          = 40,
   parameter int START_LENGTH     = 3
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic                        frame_tik,
   input  logic                        move_tik,
   input  logic [1:0]                  direction,
   input  logic                        grow,
   input  logic                        game_restart,
   output logic [6:0]                  snake_head_x,
   output logic [6:0]                  snake_head_y,
   output logic [6:0]                  snake_body_x,
   output logic [6:0]                  snake_body_y,
   output logic                        en_snake_body,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        collision,
   output logic                        busy
);

   localparam int BODY_N = SNAKE_LENGTH_MAX - 1;
   localparam logic [SNAKE_LENGTH_BIT-1:0] ONE      = SNAKE_LENGTH_BIT'(1);
   localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2);
   localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_CAP  = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
   localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_INIT = SNAKE_LENGTH_BIT'(START_LENGTH);
   localparam logic [6:0] X_MAX   = 7'(GRID_X_MAX);
   localparam logic [6:0] Y_MAX   = 7'(GRID_Y_MAX);
   localparam logic [6:0] X_START = 7'(START_X);
   localparam logic [6:0] Y_START = 7'(START_Y);

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   typedef enum logic [1:0] {IDLE, MOVE, CHECK, STREAM} state_t;

   state_t                      state, state_nxt;
   logic [6:0]                  body_x [BODY_N];
   logic [6:0]                  body_y [BODY_N];
   logic [SNAKE_LENGTH_BIT-1:0] idx, tail_idx, idx_inc, stream_sel;
   logic [1:0]                  cur_dir, new_dir;
   logic [6:0]                  next_x, next_y;
   logic                        frame_tik_q, frame_rise;
   logic                        pending, pending_grow, move_grow;
   logic                        move_go, wall_hit, body_hit;

   // Entries beyond the initial length start out stacked on the tail.
   function automatic logic [6:0] init_x(input int k);
      int kk;
      kk = (k < START_LENGTH) ? k : START_LENGTH - 1;
      return 7'(START_X - 1 - kk);
   endfunction

   assign frame_rise = frame_tik & ~frame_tik_q;
   assign move_go    = (move_tik | pending) & ~collision & ~frame_rise;
   assign tail_idx   = snake_length - ONE;
   assign idx_inc    = idx + ONE;
   assign stream_sel = (idx_inc < snake_length) ? idx_inc : tail_idx;
   assign body_hit   = (body_x[idx] == snake_head_x) && (body_y[idx] == snake_head_y);
   assign new_dir    = ((direction ^ cur_dir) == 2'b01) ? cur_dir : direction;
   assign busy       = (state != IDLE);

   // Edge tests happen before any arithmetic so 7-bit coordinates never wrap.
   always_comb begin
      next_x   = snake_head_x;
      next_y   = snake_head_y;
      wall_hit = 1'b0;
      case (new_dir)
         DIR_RIGHT: if (snake_head_x >= X_MAX) wall_hit = 1'b1; else next_x = snake_head_x + 7'd1;
         DIR_LEFT:  if (snake_head_x == 7'd0)  wall_hit = 1'b1; else next_x = snake_head_x - 7'd1;
         DIR_UP:    if (snake_head_y == 7'd0)  wall_hit = 1'b1; else next_y = snake_head_y - 7'd1;
         DIR_DOWN:  if (snake_head_y >= Y_MAX) wall_hit = 1'b1; else next_y = snake_head_y + 7'd1;
         default:   wall_hit = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (frame_rise)   state_nxt = STREAM;
            else if (move_go) state_nxt = MOVE;
         end
         MOVE:    state_nxt = wall_hit ? IDLE : CHECK;
         CHECK:   if (body_hit || idx == tail_idx) state_nxt = IDLE;
         STREAM:  if (frame_tik && idx == LAST_IDX) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (game_restart) state_nxt = IDLE;
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         frame_tik_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         frame_tik_q <= frame_tik;
      end
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         snake_head_x  <= X_START;
         snake_head_y  <= Y_START;
         for (int i = 0; i < BODY_N; i++) begin
            body_x[i] <= init_x(i);
            body_y[i] <= Y_START;
         end
         snake_length  <= LEN_INIT;
         cur_dir       <= DIR_RIGHT;
         collision     <= 1'b0;
         en_snake_body <= 1'b0;
         snake_body_x  <= 7'd0;
         snake_body_y  <= 7'd0;
         pending       <= 1'b0;
         pending_grow  <= 1'b0;
         move_grow     <= 1'b0;
         idx           <= '0;
      end else if (game_restart) begin
         snake_head_x  <= X_START;
         snake_head_y  <= Y_START;
         for (int i = 0; i < BODY_N; i++) begin
            body_x[i] <= init_x(i);
            body_y[i] <= Y_START;
         end
         snake_length  <= LEN_INIT;
         cur_dir       <= DIR_RIGHT;
         collision     <= 1'b0;
         en_snake_body <= 1'b0;
         snake_body_x  <= 7'd0;
         snake_body_y  <= 7'd0;
         pending       <= 1'b0;
         pending_grow  <= 1'b0;
         move_grow     <= 1'b0;
         idx           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_rise) begin
                  idx           <= '0;
                  en_snake_body <= 1'b1;
                  snake_body_x  <= body_x[0];
                  snake_body_y  <= body_y[0];
               end else if (move_go) begin
                  pending   <= 1'b0;
                  move_grow <= pending ? (pending_grow | (move_tik & grow)) : grow;
               end
            end
            MOVE: begin
               cur_dir <= new_dir;
               if (wall_hit) begin
                  collision <= 1'b1;
               end else begin
                  for (int i = 1; i < BODY_N; i++) begin
                     body_x[i] <= body_x[i-1];
                     body_y[i] <= body_y[i-1];
                  end
                  body_x[0]    <= snake_head_x;
                  body_y[0]    <= snake_head_y;
                  snake_head_x <= next_x;
                  snake_head_y <= next_y;
                  if (move_grow && snake_length != LEN_CAP) snake_length <= snake_length + ONE;
                  idx <= '0;
               end
            end
            CHECK: begin
               if (body_hit)              collision <= 1'b1;
               else if (idx != tail_idx)  idx <= idx_inc;
            end
            STREAM: begin
               if (frame_tik) begin
                  if (idx == LAST_IDX) begin
                     en_snake_body <= 1'b0;
                  end else begin
                     idx          <= idx_inc;
                     snake_body_x <= body_x[stream_sel];
                     snake_body_y <= body_y[stream_sel];
                  end
               end
            end
            default: idx <= '0;
         endcase
         // A tick not taken straight from IDLE is parked; only one can wait, but grow requests accumulate.
         if (move_tik && !collision && !(state == IDLE && move_go)) begin
            if (!pending) begin
               pending      <= 1'b1;
               pending_grow <= grow;
            end else begin
               pending_grow <= pending_grow | grow;
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_body_sequencer.sv
// Directed bench: stream entries are checked by a scoreboard monitor, head/length/collision by direct compares.
module tb_snake_body_sequencer;

   logic       clock_25 = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tik = 1'b0;
   logic       move_tik = 1'b0;
   logic [1:0] direction = 2'b00;
   logic       grow = 1'b0;
   logic       game_restart = 1'b0;
   logic [6:0] snake_head_x, snake_head_y, snake_body_x, snake_body_y;
   logic       en_snake_body, collision, busy;
   logic [3:0] snake_length;

   int n_vec = 0;
   int n_err = 0;
   logic [13:0] sb_q [$];

   snake_body_sequencer dut (
      .clock_25(clock_25), .reset(reset), .frame_tik(frame_tik), .move_tik(move_tik),
      .direction(direction), .grow(grow), .game_restart(game_restart),
      .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
      .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
      .en_snake_body(en_snake_body), .snake_length(snake_length),
      .collision(collision), .busy(busy)
   );

   always #20 clock_25 = ~clock_25;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Stream monitor: each cycle the renderer consumes an entry (en and frame_tik high) is scored.
   initial begin
      logic [13:0] e;
      forever begin
         @(negedge clock_25);
         if (reset && en_snake_body && frame_tik) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL stream_extra: got (%0d,%0d) expected no entry", snake_body_x, snake_body_y);
            end else begin
               e = sb_q.pop_front();
               if ({snake_body_x, snake_body_y} !== e) begin
                  n_err++;
                  $display("FAIL stream_entry: got (%0d,%0d) expected (%0d,%0d)",
                           snake_body_x, snake_body_y, e[13:7], e[6:0]);
               end
            end
         end
      end
   end

   task automatic step;
      @(posedge clock_25);
      #1;
   endtask

   task automatic push_xy(input int x, input int y);
      sb_q.push_back({7'(x), 7'(y)});
   endtask

   // Straight horizontal snake whose head is at (hx,hy): body k at (hx-1-k,hy), padded with the tail.
   task automatic push_line(input int hx, input int hy, input int len, input int n);
      for (int k = 0; k < n; k++) push_xy(hx - 1 - ((k < len) ? k : len - 1), hy);
   endtask

   task automatic wait_idle;
      int i;
      i = 0;
      while (busy && i < 60) begin
         step;
         i++;
      end
      if (busy) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 60 cycles");
      end
   endtask

   task automatic tick(input logic [1:0] d, input logic g);
      direction = d;
      grow      = g;
      move_tik  = 1'b1;
      step;
      move_tik  = 1'b0;
      grow      = 1'b0;
      wait_idle;
   endtask

   task automatic restart;
      game_restart = 1'b1;
      step;
      game_restart = 1'b0;
   endtask

   // One vsync window; with gap_at >= 0 a move tick lands mid-stream followed by 3 low cycles.
   task automatic run_frame(input int gap_at);
      frame_tik = 1'b0;
      step;
      for (int c = 0; c < 24; c++) begin
         if (c == gap_at) begin
            move_tik  = 1'b1;
            direction = 2'b00;
            grow      = 1'b0;
         end else begin
            move_tik  = 1'b0;
         end
         frame_tik = (gap_at >= 0 && c > gap_at && c <= gap_at + 3) ? 1'b0 : 1'b1;
         step;
      end
      move_tik  = 1'b0;
      frame_tik = 1'b0;
      wait_idle;
      check("stream_drain", sb_q.size(), 0);
   endtask

   initial begin
      int cyc;
      repeat (3) step;
      check("rst_head_x", snake_head_x, 60);
      check("rst_head_y", snake_head_y, 40);
      check("rst_length", snake_length, 3);
      check("rst_collision", collision, 0);
      check("rst_en", en_snake_body, 0);
      check("rst_body_x", snake_body_x, 0);
      check("rst_body_y", snake_body_y, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;
      step;

      // Initial frame
      push_line(60, 40, 3, 15);
      run_frame(-1);

      // Grow move: head moves 2 cycles after the tick
      direction = 2'b00;
      grow      = 1'b1;
      move_tik  = 1'b1;
      step;
      move_tik  = 1'b0;
      grow      = 1'b0;
      step;
      check("grow_head_x", snake_head_x, 61);
      check("grow_head_y", snake_head_y, 40);
      wait_idle;
      check("grow_length", snake_length, 4);
      check("grow_collision", collision, 0);
      push_line(61, 40, 4, 15);
      run_frame(-1);

      // Reversal request ignored
      tick(2'b01, 1'b0);
      check("rev_head_x", snake_head_x, 62);
      check("rev_head_y", snake_head_y, 40);

      // Four turns curling into the body
      tick(2'b11, 1'b0);
      check("turn1_head_y", snake_head_y, 41);
      tick(2'b00, 1'b0);
      check("turn2_head_x", snake_head_x, 63);
      tick(2'b10, 1'b0);
      check("turn3_head_y", snake_head_y, 40);
      check("turn3_collision", collision, 0);
      direction = 2'b01;
      move_tik  = 1'b1;
      cyc = 0;
      while (!collision && cyc < 6) begin
         step;
         move_tik = 1'b0;
         cyc++;
      end
      move_tik = 1'b0;
      check("self_collision", collision, 1);
      check("self_head_x", snake_head_x, 62);
      wait_idle;
      push_xy(63, 40);
      push_xy(63, 41);
      push_xy(62, 41);
      for (int k = 0; k < 12; k++) push_xy(62, 40);
      run_frame(-1);

      // Pending tick during a stalled stream
      restart;
      check("restart_length", snake_length, 3);
      check("restart_collision", collision, 0);
      check("restart_head_x", snake_head_x, 60);
      push_line(60, 40, 3, 15);
      run_frame(5);
      check("pending_head_x", snake_head_x, 61);
      check("pending_length", snake_length, 3);
      repeat (5) step;
      check("pending_once_x", snake_head_x, 61);

      // Wall at the right edge
      for (int k = 0; k < 62; k++) tick(2'b00, 1'b0);
      check("edge_head_x", snake_head_x, 123);
      check("edge_collision", collision, 0);
      tick(2'b00, 1'b0);
      repeat (2) step;
      check("wall_collision", collision, 1);
      check("wall_head_x", snake_head_x, 123);
      tick(2'b11, 1'b0);
      repeat (3) step;
      check("dead_head_y", snake_head_y, 40);
      check("dead_head_x", snake_head_x, 123);
      push_line(123, 40, 3, 15);
      run_frame(-1);

      // Growth saturation, then restart mid-stream
      restart;
      for (int k = 0; k < 12; k++) tick(2'b00, 1'b1);
      check("len_at_cap", snake_length, 15);
      for (int k = 0; k < 4; k++) tick(2'b00, 1'b1);
      check("len_saturated", snake_length, 15);
      check("sat_head_x", snake_head_x, 76);
      push_line(76, 40, 15, 5);
      frame_tik = 1'b0;
      step;
      frame_tik = 1'b1;
      repeat (5) step;
      game_restart = 1'b1;
      step;
      game_restart = 1'b0;
      check("midrst_en", en_snake_body, 0);
      check("midrst_busy", busy, 0);
      check("midrst_length", snake_length, 3);
      check("midrst_head_x", snake_head_x, 60);
      check("midrst_collision", collision, 0);
      check("midrst_drain", sb_q.size(), 0);
      push_line(60, 40, 3, 15);
      run_frame(-1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
